// File: rtl/truth_table_sweeper.sv
// Exhaustive sweeper: drives every N-bit vector to a function block and scores its output against TRUTH.
// Latency: one vector per clock; results valid 2^N+LAT cycles after the cycle following start.
// Backpressure: none; start is only honoured in IDLE or DONE and ignored while busy.
module truth_table_sweeper #(
    parameter int                N     = 5,
    parameter logic [(1<<N)-1:0] TRUTH = 32'hB37C_644A,
    parameter int                LAT   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] dut_in,
    input  logic         dut_f,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic [N:0]   ones_cnt,
    output logic [N-1:0] first_err_idx,
    output logic         first_err_vld
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [N-1:0] LAST_IDX = '1;
    localparam logic [N-1:0] ONE_IDX  = 1;
    localparam logic [N:0]   ONE_CNT  = 1;
    localparam logic [2:0]   LAT_M1   = 3'(LAT - 1);

    state_t       state;
    logic [2:0]   lat_cnt;
    logic         cmp_vld;
    logic [N-1:0] cmp_idx;

    // dut_in doubles as the sweep index: it is 0 outside RUN because it wraps on the last vector.
    generate
        if (LAT == 0) begin : g_comb
            assign cmp_vld = (state == RUN);
            assign cmp_idx = dut_in;
        end else begin : g_pipe
            logic [LAT-1:0] pipe_vld;
            logic [N-1:0]   pipe_idx [LAT];

            // Delay {valid, index} by LAT clocks so each dut_f is scored against the vector that produced it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_vld <= '0;
                    for (int k = 0; k < LAT; k++) pipe_idx[k] <= '0;
                end else begin
                    pipe_vld[0] <= (state == RUN);
                    pipe_idx[0] <= dut_in;
                    for (int k = 1; k < LAT; k++) begin
                        pipe_vld[k] <= pipe_vld[k-1];
                        pipe_idx[k] <= pipe_idx[k-1];
                    end
                end
            end

            assign cmp_vld = pipe_vld[LAT-1];
            assign cmp_idx = pipe_idx[LAT-1];
        end
    endgenerate

    // Sweep FSM plus scoring; a clear on accepted start overrides any scoring update in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dut_in        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lat_cnt       <= '0;
            err_cnt       <= '0;
            ones_cnt      <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else begin
            if (cmp_vld) begin
                if (dut_f != TRUTH[cmp_idx]) begin
                    err_cnt <= err_cnt + ONE_CNT;
                    if (!first_err_vld) begin
                        first_err_idx <= cmp_idx;
                        first_err_vld <= 1'b1;
                    end
                end
                if (dut_f) ones_cnt <= ones_cnt + ONE_CNT;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        dut_in        <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        err_cnt       <= '0;
                        ones_cnt      <= '0;
                        first_err_idx <= '0;
                        first_err_vld <= 1'b0;
                    end
                end
                RUN: begin
                    if (dut_in == LAST_IDX) begin
                        dut_in <= '0;
                        if (LAT > 0) begin
                            state   <= DRAIN;
                            lat_cnt <= '0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        dut_in <= dut_in + ONE_IDX;
                    end
                end
                DRAIN: begin
                    if (lat_cnt == LAT_M1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // pass is a pure decode of registered results, so it is stable whenever done is.
    assign pass = done && (err_cnt == '0);

endmodule
